// File: rtl/baccarat_pkg.sv
// Shared definitions for the baccarat game sequencer: state encodings,
// scoring thresholds and the card-rank to point-value mapping.
package baccarat_pkg;

    // Sequencer states; encodings 9..15 are illegal and recover to DEAL_P1.
    typedef enum logic [3:0] {
        DEAL_P1 = 4'd0,
        DEAL_D1 = 4'd1,
        DEAL_P2 = 4'd2,
        DEAL_D2 = 4'd3,
        CHECK   = 4'd4,
        DEAL_P3 = 4'd5,
        CHECK_D = 4'd6,
        DEAL_D3 = 4'd7,
        DONE    = 4'd8
    } state_t;

    // Two-card total at or above this ends the hand immediately.
    localparam logic [3:0] NATURAL_MIN      = 4'd8;
    // Player stands on this total or more; below it the player draws.
    localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;

    // Point value of a card rank: A..9 count face value, 10/J/Q/K and an
    // empty slot (rank 0) count zero.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        if ((rank >= 4'd1) && (rank <= 4'd9)) begin
            return rank;
        end
        return 4'd0;
    endfunction

endpackage

// File: rtl/deal_fsm_banker_rule.sv
// Banker third-card decision table, applied once the player has drawn a
// third card. Purely combinational so it can be exercised exhaustively.
module banker_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] v;

    // Decide whether the banker draws, from its total and the player's third-card value.
    always_comb begin
        v    = card_value(pcard3);
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            // 7 stands; 8 and above never reach this point in a legal hand.
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/deal_fsm.sv
// Baccarat game sequencer. Moore machine clocked on the falling edge of
// slow_clock, the same edge on which the card datapath loads, so each
// strobe is held for a full period before the edge that consumes it.
module deal_fsm
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       game_over
);

    // Plain-vector view of the state encodings so illegal codes decode safely.
    localparam logic [3:0] ST_DEAL_P1 = DEAL_P1;
    localparam logic [3:0] ST_DEAL_D1 = DEAL_D1;
    localparam logic [3:0] ST_DEAL_P2 = DEAL_P2;
    localparam logic [3:0] ST_DEAL_D2 = DEAL_D2;
    localparam logic [3:0] ST_CHECK   = CHECK;
    localparam logic [3:0] ST_DEAL_P3 = DEAL_P3;
    localparam logic [3:0] ST_CHECK_D = CHECK_D;
    localparam logic [3:0] ST_DEAL_D3 = DEAL_D3;
    localparam logic [3:0] ST_DONE    = DONE;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       banker_draw;
    logic       natural;
    logic       player_stands;
    logic       banker_low;

    banker_rule u_banker_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (banker_draw)
    );

    // Two-card decisions taken in CHECK.
    assign natural       = (pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN);
    assign player_stands = (pscore >= PLAYER_STAND_MIN);
    // When the player stands, the banker draws on 0..5 and stands on 6/7.
    assign banker_low    = (dscore < PLAYER_STAND_MIN);

    // State register; reset restarts the deal from any point in the hand.
    always_ff @(negedge slow_clock) begin
        if (!resetb) begin
            state_q <= ST_DEAL_P1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed four-card deal, then the drawing rules.
    always_comb begin
        state_d = ST_DEAL_P1;
        case (state_q)
            ST_DEAL_P1: state_d = ST_DEAL_D1;
            ST_DEAL_D1: state_d = ST_DEAL_P2;
            ST_DEAL_P2: state_d = ST_DEAL_D2;
            ST_DEAL_D2: state_d = ST_CHECK;
            ST_CHECK: begin
                if (natural) begin
                    state_d = ST_DONE;
                end else if (!player_stands) begin
                    state_d = ST_DEAL_P3;
                end else if (banker_low) begin
                    state_d = ST_DEAL_D3;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DEAL_P3: state_d = ST_CHECK_D;
            ST_CHECK_D: state_d = banker_draw ? ST_DEAL_D3 : ST_DONE;
            ST_DEAL_D3: state_d = ST_DONE;
            ST_DONE:    state_d = ST_DONE;
            default:    state_d = ST_DEAL_P1;
        endcase
    end

    // Output decode: one strobe per deal state, lights only once the hand is done.
    always_comb begin
        load_pcard1      = 1'b0;
        load_pcard2      = 1'b0;
        load_pcard3      = 1'b0;
        load_dcard1      = 1'b0;
        load_dcard2      = 1'b0;
        load_dcard3      = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        game_over        = 1'b0;
        case (state_q)
            ST_DEAL_P1: load_pcard1 = 1'b1;
            ST_DEAL_D1: load_dcard1 = 1'b1;
            ST_DEAL_P2: load_pcard2 = 1'b1;
            ST_DEAL_D2: load_dcard2 = 1'b1;
            ST_DEAL_P3: load_pcard3 = 1'b1;
            ST_DEAL_D3: load_dcard3 = 1'b1;
            ST_DONE: begin
                game_over        = 1'b1;
                // A tie lights both indicators.
                player_win_light = (pscore >= dscore);
                dealer_win_light = (dscore >= pscore);
            end
            default: ;
        endcase
    end

endmodule
